// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command bridge.
//   ser_state_e        : transmit serializer state encoding (2-bit)
//   CNT_W              : width of the saturating monitor counters
//   TIMEOUT_CYCLES_DEF : default inter-byte timeout (1 ms at 40 MHz)
//   sat_inc()          : increment that sticks at all-ones
package uart_cmd_pkg;

  localparam int unsigned CNT_W              = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 40000;

  typedef enum logic [1:0] {
    SER_IDLE      = 2'd0,
    SER_START     = 2'd1,
    SER_WAIT_BUSY = 2'd2,
    SER_WAIT_DONE = 2'd3
  } ser_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/uart_cmd_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered head/flags.
//   clk_i, rst_i (sync, active-high)
//   wr_en_i/wr_data_i : push, ignored when full (even with a same-cycle pop)
//   rd_en_i           : pop, ignored when empty
//   rd_data_o         : current head (0 when empty), empty_o, full_o
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]    head_q, head_d;
  logic                empty_q, empty_d, full_q, full_d;
  logic                wr_ok, rd_ok;

  // Pointer update and look-ahead of the next head word
  always_comb begin
    wr_ok    = wr_en_i && !full_q;
    rd_ok    = rd_en_i && !empty_q;
    wr_ptr_d = wr_ok ? wr_ptr_q + (DEPTH_LOG2+1)'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + (DEPTH_LOG2+1)'(1) : rd_ptr_q;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d == {~rd_ptr_d[DEPTH_LOG2], rd_ptr_d[DEPTH_LOG2-1:0]});
    // A write into the slot that becomes the head bypasses the memory
    if (empty_d)
      head_d = '0;
    else if (wr_ok && (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]))
      head_d = wr_data_i;
    else
      head_d = mem_q[rd_ptr_d[DEPTH_LOG2-1:0]];
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
  end

  // Pointers and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign rd_data_o = head_q;
  assign empty_o   = empty_q;
  assign full_o    = full_q;

endmodule

// File: rtl/uart_cmd_bridge.sv
// Byte-stream <-> command-word bridge in front of the UART byte core.
//   RX: rx_data/rx_ready/rx_parity_error -> frame assembly -> command FIFO
//       (cmd_rd_en, cmd_data FWFT head, cmd_empty)
//   TX: rsp_wr_en/rsp_data -> response FIFO (rsp_full) -> serializer
//       driving tx_data/tx_start against tx_ready
//   Status: rx_busy, tx_busy, saturating frame_err/timeout/cmd_ovf/rsp_ovf counts
// Optional macro UART_CMD_CHECKSUM_EN adds a trailing XOR byte on both paths.
module uart_cmd_bridge
  import uart_cmd_pkg::*;
#(
  parameter int unsigned FRAME_BYTES    = 20,
  parameter int unsigned RSP_BYTES      = 20,
  parameter int unsigned CMD_DEPTH_LOG2 = 4,
  parameter int unsigned RSP_DEPTH_LOG2 = 2,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                     clk40,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_ready,
  input  logic                     rx_parity_error,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_ready,
  input  logic                     cmd_rd_en,
  output logic [8*FRAME_BYTES-1:0] cmd_data,
  output logic                     cmd_empty,
  input  logic                     rsp_wr_en,
  input  logic [8*RSP_BYTES-1:0]   rsp_data,
  output logic                     rsp_full,
  output logic                     rx_busy,
  output logic                     tx_busy,
  output logic [CNT_W-1:0]         frame_err_cnt,
  output logic [CNT_W-1:0]         timeout_cnt,
  output logic [CNT_W-1:0]         cmd_ovf_cnt,
  output logic [CNT_W-1:0]         rsp_ovf_cnt
);

  localparam int unsigned CMD_W = 8 * FRAME_BYTES;
  localparam int unsigned RSP_W = 8 * RSP_BYTES;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int unsigned RX_BYTES = FRAME_BYTES + 1;
  localparam int unsigned TX_BYTES = RSP_BYTES + 1;
`else
  localparam int unsigned RX_BYTES = FRAME_BYTES;
  localparam int unsigned TX_BYTES = RSP_BYTES;
`endif
  localparam int unsigned TX_W   = 8 * TX_BYTES;
  localparam int unsigned BCNT_W = $clog2(RX_BYTES + 1);
  localparam int unsigned IDX_W  = $clog2(TX_BYTES + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------- receive path ----------------
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CMD_W-1:0]  frame_q, frame_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              push_q, push_d, rx_busy_q;
  logic [CNT_W-1:0]  ferr_q, ferr_d, tmo_q, tmo_d, cmd_ovf_q, rsp_ovf_q;
  logic              cmd_full;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // Frame assembly, parity/checksum abort and inter-byte timeout
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    frame_d    = frame_q;
    idle_d     = idle_q;
    push_d     = 1'b0;
    ferr_d     = ferr_q;
    tmo_d      = tmo_q;
`ifdef UART_CMD_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (rx_ready) begin
      idle_d = '0;
      if (rx_parity_error) begin
        byte_cnt_d = '0;
        ferr_d     = sat_inc(ferr_q);
`ifdef UART_CMD_CHECKSUM_EN
      end else if (byte_cnt_q == BCNT_W'(FRAME_BYTES)) begin
        // Trailing checksum byte: compared, never stored
        byte_cnt_d = '0;
        if (rx_data == csum_q) push_d = 1'b1;
        else                   ferr_d = sat_inc(ferr_q);
`endif
      end else begin
        frame_d = (frame_q << 8) | CMD_W'(rx_data);
`ifdef UART_CMD_CHECKSUM_EN
        csum_d  = (byte_cnt_q == '0) ? rx_data : (csum_q ^ rx_data);
`endif
        if (byte_cnt_q == BCNT_W'(RX_BYTES - 1)) begin
          byte_cnt_d = '0;
          push_d     = 1'b1;
        end else begin
          byte_cnt_d = byte_cnt_q + BCNT_W'(1);
        end
      end
    end else if (byte_cnt_q != '0) begin
      if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        byte_cnt_d = '0;
        idle_d     = '0;
        tmo_d      = sat_inc(tmo_q);
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk40) begin
    if (reset) begin
      byte_cnt_q <= '0;
      frame_q    <= '0;
      idle_q     <= '0;
      push_q     <= 1'b0;
      rx_busy_q  <= 1'b0;
      ferr_q     <= '0;
      tmo_q      <= '0;
      cmd_ovf_q  <= '0;
      rsp_ovf_q  <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      frame_q    <= frame_d;
      idle_q     <= idle_d;
      push_q     <= push_d;
      rx_busy_q  <= (byte_cnt_d != '0);
      ferr_q     <= ferr_d;
      tmo_q      <= tmo_d;
      if (push_q && cmd_full)   cmd_ovf_q <= sat_inc(cmd_ovf_q);
      if (rsp_wr_en && rsp_full) rsp_ovf_q <= sat_inc(rsp_ovf_q);
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  always_ff @(posedge clk40) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  sync_fifo #(.WIDTH(CMD_W), .DEPTH_LOG2(CMD_DEPTH_LOG2)) u_cmd_fifo (
    .clk_i(clk40), .rst_i(reset), .wr_en_i(push_q), .wr_data_i(frame_q),
    .rd_en_i(cmd_rd_en), .rd_data_o(cmd_data), .empty_o(cmd_empty), .full_o(cmd_full)
  );

  // ---------------- transmit path ----------------
  logic [RSP_W-1:0] rsp_head;
  logic             rsp_empty, rsp_pop;
  logic [TX_W-1:0]  tx_word, shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d, tx_busy_q;
  ser_state_e       state_q, state_d;

  sync_fifo #(.WIDTH(RSP_W), .DEPTH_LOG2(RSP_DEPTH_LOG2)) u_rsp_fifo (
    .clk_i(clk40), .rst_i(reset), .wr_en_i(rsp_wr_en), .wr_data_i(rsp_data),
    .rd_en_i(rsp_pop), .rd_data_o(rsp_head), .empty_o(rsp_empty), .full_o(rsp_full)
  );

`ifdef UART_CMD_CHECKSUM_EN
  // Response word with its XOR byte appended as the last byte
  always_comb begin
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < int'(RSP_BYTES); i++) x = x ^ rsp_head[8*i +: 8];
    tx_word = {rsp_head, x};
  end
`else
  assign tx_word = rsp_head;
`endif

  // Serializer state register
  always_ff @(posedge clk40) begin
    if (reset) state_q <= SER_IDLE;
    else       state_q <= state_d;
  end

  // Serializer next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      SER_IDLE:      if (!rsp_empty) state_d = SER_START;
      SER_START:     if (tx_ready)   state_d = SER_WAIT_BUSY;
      SER_WAIT_BUSY: if (!tx_ready)  state_d = SER_WAIT_DONE;
      SER_WAIT_DONE: if (tx_ready)
                       state_d = (idx_q == IDX_W'(TX_BYTES - 1)) ? SER_IDLE : SER_START;
      default:       state_d = SER_IDLE;
    endcase
  end

  // Serializer outputs and datapath; tx_data only changes on entry to START
  always_comb begin
    shift_d    = shift_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    rsp_pop    = 1'b0;
    case (state_q)
      SER_IDLE: if (!rsp_empty) begin
        rsp_pop   = 1'b1;
        shift_d   = tx_word;
        idx_d     = '0;
        tx_data_d = tx_word[TX_W-1 -: 8];
      end
      SER_START: if (tx_ready) tx_start_d = 1'b1;
      SER_WAIT_DONE: if (tx_ready && (idx_q != IDX_W'(TX_BYTES - 1))) begin
        idx_d     = idx_q + IDX_W'(1);
        shift_d   = shift_q << 8;
        tx_data_d = shift_d[TX_W-1 -: 8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk40) begin
    if (reset) begin
      shift_q    <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      tx_busy_q  <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      tx_busy_q  <= (state_d != SER_IDLE);
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_start      = tx_start_q;
  assign tx_busy       = tx_busy_q;
  assign rx_busy       = rx_busy_q;
  assign frame_err_cnt = ferr_q;
  assign timeout_cnt   = tmo_q;
  assign cmd_ovf_cnt   = cmd_ovf_q;
  assign rsp_ovf_cnt   = rsp_ovf_q;

endmodule

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
Parametrised byte-stream to command-word bridge between the UART byte core (uart_top) and the command/readback logic. Receive side: assembles FRAME_BYTES received bytes into one command word, with a parity abort and an inter-byte timeout resync, then buffers words in an internal FIFO. Transmit side: adds a response FIFO and a serializer that drives the edge-sensitive tx_start/tx_ready handshake byte by byte. Error/overflow counters are exposed for monitoring.

Parameters:
FRAME_BYTES, 20, bytes per command word; cmd_data width = 8*FRAME_BYTES
RSP_BYTES, 20, bytes per response word; rsp_data width = 8*RSP_BYTES
CMD_DEPTH_LOG2, 4, command FIFO depth = 2**CMD_DEPTH_LOG2 words
RSP_DEPTH_LOG2, 2, response FIFO depth = 2**RSP_DEPTH_LOG2 words
TIMEOUT_CYCLES, 40000, idle cycles inside a partial frame before discard (1 ms at 40 MHz)

Ports:
clk40  in  1  single clock, 40 MHz
reset  in  1  synchronous, active-high
rx_data  in  8  received byte from UART core
rx_ready  in  1  one-cycle strobe, rx_data valid
rx_parity_error  in  1  qualifies rx_ready; byte bad
tx_data  out  8  byte to UART core
tx_start  out  1  one-cycle start pulse to UART core
tx_ready  in  1  UART core idle/ready
cmd_rd_en  in  1  pop command word
cmd_data  out  8*FRAME_BYTES  FWFT head of command FIFO
cmd_empty  out  1  command FIFO empty
rsp_wr_en  in  1  push response word
rsp_data  in  8*RSP_BYTES  response word
rsp_full  out  1  response FIFO full
rx_busy  out  1  partial frame in progress
tx_busy  out  1  serializer not IDLE
frame_err_cnt  out  8  saturating count of parity/checksum aborts
timeout_cnt  out  8  saturating count of timeout discards
cmd_ovf_cnt  out  8  saturating count of frames dropped on full command FIFO
rsp_ovf_cnt  out  8  saturating count of response writes dropped on full response FIFO

Behaviour:
- Reset: all FIFOs emptied. cmd_empty=1, rsp_full=0, tx_start=0, tx_data=0, rx_busy=0, tx_busy=0, all counters 0, cmd_data=0. Reset mid-frame or mid-byte discards everything. The serializer returns to IDLE without waiting for tx_ready.
- Assembly: MSB-first; the first byte of a frame lands in cmd_data[8*FRAME_BYTES-1 -: 8]. byte_cnt runs 0..FRAME_BYTES-1. rx_busy = (byte_cnt!=0).
- Parity abort: rx_ready with rx_parity_error=1 clears byte_cnt, drops the partial frame and increments frame_err_cnt. This also applies at byte_cnt=0.
- Timeout: the idle counter clears on every rx_ready and counts only while rx_busy. On reaching TIMEOUT_CYCLES-1 it clears byte_cnt and increments timeout_cnt. If rx_ready arrives in the same cycle as expiry, rx_ready wins and there is no timeout.
- Push: the cycle after the last good byte, the frame is written to the command FIFO. cmd_empty falls 2 cycles after the final rx_ready. If the FIFO is full at push, the frame is dropped and cmd_ovf_cnt increments.
- FIFOs: first-word fall-through (FWFT). Read on empty is ignored. Write on full is ignored, even with a same-cycle read. Simultaneous read and write on a non-empty, non-full FIFO keeps occupancy unchanged.
- rsp_wr_en while rsp_full drops the word and increments rsp_ovf_cnt.
- All counters saturate at 255; no wrap.
- Serializer states: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - IDLE: if the response FIFO is non-empty, pop the word into the shift register, set idx=0, go to START.
  - START: tx_data = current byte (MSB-first). When tx_ready=1, assert tx_start for exactly one cycle and go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_ready=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_ready=1. If idx==RSP_BYTES-1 go to IDLE; else idx++, shift, go to START.
- tx_start is never high on two consecutive cycles. tx_data is held stable from START until the WAIT_DONE exit.

Optional Feature:
- Macro UART_CMD_CHECKSUM_EN.
- Defined, receive: frames are FRAME_BYTES+1 bytes. The trailing byte must equal the XOR of the payload bytes. On mismatch the frame is discarded and frame_err_cnt increments; the checksum byte is never stored.
- Defined, transmit: the serializer appends the XOR byte of the response after RSP_BYTES bytes, with the same handshake.
- Undefined: no checksum bytes; the checksum logic is absent.

Decomposition:
- Package uart_cmd_pkg holds:
  - the serializer state encoding (2-bit)
  - the saturating-counter width constant CNT_W=8
  - the default TIMEOUT_CYCLES value
- Sub-module sync_fifo (parameters WIDTH, DEPTH_LOG2; FWFT; synchronous active-high reset) is instantiated twice.

Test Plan:
Bench overrides: FRAME_BYTES=4, RSP_BYTES=2, CMD_DEPTH_LOG2=2, TIMEOUT_CYCLES=100.
- Good frame: bytes 0xDE,0xAD,0xBE,0xEF, no parity errors -> cmd_empty falls 2 cycles after the 4th rx_ready; cmd_data=0xDEADBEEF; cmd_rd_en pulse -> cmd_empty=1.
- Parity abort: 2 bytes, then a byte with parity error, then 0x01..0x04 -> frame_err_cnt=1; only 0x01020304 stored.
- Timeout: 0x11,0x22, 100 idle cycles, then 0xA1..0xA4 -> timeout_cnt=1; cmd_data=0xA1A2A3A4.
- Overflow: 5 good frames with no reads -> 4 words stored, cmd_ovf_cnt=1; reads return frames 1-4 in order.
- Response: rsp_data=0x55AA pushed; UART model drops tx_ready 3 cycles after each tx_start and holds it low 20 cycles -> tx_data 0x55 then 0xAA, exactly 2 tx_start pulses, tx_busy returns 0.
- Checksum build: 0x01,0x02,0x03,0x04,0x04 accepted; trailing 0x05 rejected with frame_err_cnt=1; response 0x55AA sends 0x55,0xAA,0xFF.
